// File: rtl/osf_pipe_arbiter_pkg.sv
// Shared pipe-frame definitions: header sync/field layout and arbiter FSM states.
// The host-side decoder uses the same header layout.
package osf_pipe_arbiter_pkg;

   localparam logic [3:0] HDR_SYNC     = 4'hA;
   localparam int         HDR_SYNC_LSB = 12;
   localparam int         HDR_CHAN_LSB = 8;
   localparam int         HDR_DROP_BIT = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   function automatic logic [15:0] make_hdr(input logic [3:0] chan, input logic drop);
      logic [15:0] h;
      h = '0;
      h[HDR_SYNC_LSB +: 4] = HDR_SYNC;
      h[HDR_CHAN_LSB +: 4] = chan;
      h[HDR_DROP_BIT]      = drop;
      return h;
   endfunction

endpackage

// File: rtl/osf_pipe_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after the last-grant pointer.
// The pointer register lives in the parent.
module rr_arbiter #(
   parameter int N  = 8,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   int c;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      c     = 0;
      for (int k = 1; k <= N; k++) begin
         c = (int'(last_i) + k) % N;
         if (!any_o && req_i[c]) begin
            any_o    = 1'b1;
            gnt_o[c] = 1'b1;
            idx_o    = IW'(c);
         end
      end
   end

endmodule

// File: rtl/osf_pipe_arbiter.sv
// Shares the pipe TX FIFO among all filter channels: holds each channel's newest
// sample, picks round-robin, and emits a header + data frame on a valid/ready port.
module osf_pipe_arbiter
   import osf_pipe_arbiter_pkg::*;
#(
   parameter int N_ADC      = 8,
   parameter int W_ADC_DATA = 18,
   parameter int W_EP       = 16,
   parameter int W_CNT      = 16
) (
   input  logic                        clk50_in,
   input  logic                        reset_in,
   input  logic [N_ADC-1:0]            chan_en_in,
   input  logic [N_ADC-1:0]            osf_data_valid_in,
   input  logic [N_ADC*W_ADC_DATA-1:0] osf_data_packed_in,
   input  logic                        fifo_ready_in,
   output logic                        word_valid_out,
   output logic [W_EP-1:0]             word_out,
   output logic [N_ADC-1:0]            drop_flags_out,
   input  logic                        clear_drops_in,
   output logic [W_CNT-1:0]            frame_count_out,
   output logic                        busy_out
);

   localparam int IW = (N_ADC > 1) ? $clog2(N_ADC) : 1;

   state_e                state_q, state_d;
   logic [N_ADC-1:0]      pend_q, pend_d, dsg_q, dsg_d, drop_q, drop_d;
   logic [W_ADC_DATA-1:0] hold_q [N_ADC];
   logic [W_ADC_DATA-1:0] hold_d [N_ADC];
   logic [IW-1:0]         last_q, last_d, frm_chan_q, frm_chan_d, gnt_idx;
   logic [W_EP-1:0]       frm_data_q, frm_data_d, word_q, word_d;
   logic                  frm_drop_q, frm_drop_d, vld_q, vld_d;
   logic [W_CNT-1:0]      cnt_q, cnt_d;
   logic [N_ADC-1:0]      req, gnt_oh, cap, take;
   logic [W_ADC_DATA-1:0] gnt_hold;
   logic                  any_req, grant;

   assign req   = pend_q & chan_en_in;
   assign cap   = osf_data_valid_in & chan_en_in;
   assign grant = (state_q == ST_IDLE) && any_req;
   assign take  = grant ? gnt_oh : '0;

   rr_arbiter #(.N(N_ADC), .IW(IW)) u_rr (
      .req_i  (req),
      .last_i (last_q),
      .gnt_o  (gnt_oh),
      .idx_o  (gnt_idx),
      .any_o  (any_req)
   );

   // A capture on the channel being granted is not an overrun: the frame takes
   // the old hold value and the new sample simply stays pending.
   always_comb begin
      pend_d = pend_q;
      dsg_d  = dsg_q;
      drop_d = clear_drops_in ? '0 : drop_q;
      for (int i = 0; i < N_ADC; i++) begin
         hold_d[i] = cap[i] ? osf_data_packed_in[i*W_ADC_DATA +: W_ADC_DATA] : hold_q[i];
         if (!chan_en_in[i]) begin
            pend_d[i] = 1'b0;
            dsg_d[i]  = 1'b0;
         end else if (cap[i]) begin
            pend_d[i] = 1'b1;
            if (take[i]) begin
               dsg_d[i] = 1'b0;
            end else if (pend_q[i]) begin
               dsg_d[i]  = 1'b1;
               drop_d[i] = 1'b1;
            end
         end else if (take[i]) begin
            pend_d[i] = 1'b0;
            dsg_d[i]  = 1'b0;
         end
      end
   end

   assign gnt_hold   = hold_q[gnt_idx];
   assign frm_chan_d = grant ? gnt_idx : frm_chan_q;
   assign frm_data_d = grant ? gnt_hold[W_ADC_DATA-1 -: W_EP] : frm_data_q;
   assign frm_drop_d = grant ? dsg_q[gnt_idx] : frm_drop_q;
   assign last_d     = grant ? gnt_idx : last_q;
   assign cnt_d      = (state_q == ST_DATA && fifo_ready_in) ? cnt_q + W_CNT'(1) : cnt_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (any_req)       state_d = ST_HDR;
         ST_HDR:  if (fifo_ready_in) state_d = ST_DATA;
         ST_DATA: if (fifo_ready_in) state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   // Output word is registered from the next state so it is stable while stalled.
   always_comb begin
      vld_d  = 1'b0;
      word_d = '0;
      case (state_d)
         ST_HDR: begin
            vld_d  = 1'b1;
            word_d = W_EP'(make_hdr(4'(frm_chan_d), frm_drop_d));
         end
         ST_DATA: begin
            vld_d  = 1'b1;
            word_d = frm_data_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk50_in) begin
      if (reset_in) begin
         state_q    <= ST_IDLE;
         pend_q     <= '0;
         dsg_q      <= '0;
         drop_q     <= '0;
         last_q     <= IW'(N_ADC - 1);
         frm_chan_q <= '0;
         frm_data_q <= '0;
         frm_drop_q <= 1'b0;
         vld_q      <= 1'b0;
         word_q     <= '0;
         cnt_q      <= '0;
         for (int i = 0; i < N_ADC; i++) hold_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         dsg_q      <= dsg_d;
         drop_q     <= drop_d;
         last_q     <= last_d;
         frm_chan_q <= frm_chan_d;
         frm_data_q <= frm_data_d;
         frm_drop_q <= frm_drop_d;
         vld_q      <= vld_d;
         word_q     <= word_d;
         cnt_q      <= cnt_d;
         for (int i = 0; i < N_ADC; i++) hold_q[i] <= hold_d[i];
      end
   end

   assign word_valid_out  = vld_q;
   assign word_out        = word_q;
   assign drop_flags_out  = drop_q;
   assign frame_count_out = cnt_q;
   assign busy_out        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_osf_pipe_arbiter.sv
// Directed bench for osf_pipe_arbiter: latency, backpressure, round-robin order,
// overrun flags, same-cycle capture/grant and mid-frame reset.
module tb_osf_pipe_arbiter;

   localparam int N = 8, WD = 18, WE = 16, WC = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    en, vin;
   logic [N*WD-1:0] pk;
   logic            rdy, clr;
   logic            wv;
   logic [WE-1:0]   w;
   logic [N-1:0]    drops;
   logic [WC-1:0]   fc;
   logic            busy;
   int              checks = 0;
   int              failures = 0;

   always #5 clk = ~clk;

   osf_pipe_arbiter #(.N_ADC(N), .W_ADC_DATA(WD), .W_EP(WE), .W_CNT(WC)) dut (
      .clk50_in           (clk),
      .reset_in           (rst),
      .chan_en_in         (en),
      .osf_data_valid_in  (vin),
      .osf_data_packed_in (pk),
      .fifo_ready_in      (rdy),
      .word_valid_out     (wv),
      .word_out           (w),
      .drop_flags_out     (drops),
      .clear_drops_in     (clr),
      .frame_count_out    (fc),
      .busy_out           (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int ch, input logic [WD-1:0] v);
      vin[ch] = 1'b1;
      pk[ch*WD +: WD] = v;
   endtask

   // Waits (bounded) for a valid word with ready high and consumes it.
   task automatic get_word(output logic [WE-1:0] wd, output bit ok);
      ok = 1'b0;
      wd = '0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (wv) begin
            wd = w;
            ok = 1'b1;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = '1; vin = '0; pk = '0; rdy = 1'b1; clr = 1'b0;
      tick(); tick();
      checks++; if (wv !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", wv); end
      checks++; if (w !== 16'h0) begin failures++; $display("FAIL reset_word got=%h exp=0000", w); end
      checks++; if (drops !== 8'h0) begin failures++; $display("FAIL reset_drops got=%h exp=00", drops); end
      checks++; if (fc !== 16'h0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fc); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      rdy = 1'b1;
      put(3, 18'h2ABCD);
      tick();
      vin = '0;
      checks++; if (wv !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_pending valid=%b busy=%b exp=0,0", wv, busy); end
      tick();
      checks++; if (wv !== 1'b1 || w !== 16'hA300 || busy !== 1'b1) begin failures++; $display("FAIL single_hdr valid=%b word=%h busy=%b exp=1,A300,1", wv, w, busy); end
      tick();
      checks++; if (wv !== 1'b1 || w !== 16'hAAF3) begin failures++; $display("FAIL single_data valid=%b word=%h exp=1,AAF3", wv, w); end
      tick();
      checks++; if (wv !== 1'b0 || fc !== 16'd1 || busy !== 1'b0) begin failures++; $display("FAIL single_done valid=%b count=%0d busy=%b exp=0,1,0", wv, fc, busy); end
   endtask

   task automatic test_backpressure();
      rdy = 1'b0;
      put(3, 18'h2ABCD);
      tick();
      vin = '0;
      tick();
      checks++; if (wv !== 1'b1 || w !== 16'hA300) begin failures++; $display("FAIL bp_hdr valid=%b word=%h exp=1,A300", wv, w); end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (wv !== 1'b1 || w !== 16'hA300) begin failures++; $display("FAIL bp_hold%0d valid=%b word=%h exp=1,A300", i, wv, w); end
      end
      rdy = 1'b1;
      tick();
      checks++; if (wv !== 1'b1 || w !== 16'hAAF3) begin failures++; $display("FAIL bp_data valid=%b word=%h exp=1,AAF3", wv, w); end
      rdy = 1'b0;
      tick();
      checks++; if (wv !== 1'b1 || w !== 16'hAAF3) begin failures++; $display("FAIL bp_data_hold valid=%b word=%h exp=1,AAF3", wv, w); end
      rdy = 1'b1;
      tick();
      checks++; if (wv !== 1'b0 || fc !== 16'd2) begin failures++; $display("FAIL bp_done valid=%b count=%0d exp=0,2", wv, fc); end
   endtask

   task automatic test_round_robin();
      logic [WE-1:0] exp1 [6] = '{16'hA000, 16'h0100, 16'hA200, 16'h0200, 16'hA500, 16'h0500};
      logic [WE-1:0] exp2 [4] = '{16'hA000, 16'h0101, 16'hA500, 16'h0502};
      logic [WE-1:0] got;
      bit            ok;
      rst = 1'b1; tick(); rst = 1'b0;
      rdy = 1'b1;
      put(0, 18'h00400); put(2, 18'h00800); put(5, 18'h01400);
      tick();
      vin = '0;
      for (int i = 0; i < 6; i++) begin
         get_word(got, ok);
         checks++; if (!ok || got !== exp1[i]) begin failures++; $display("FAIL rr_first%0d got=%h ok=%b exp=%h", i, got, ok, exp1[i]); end
      end
      checks++; if (fc !== 16'd3) begin failures++; $display("FAIL rr_count got=%0d exp=3", fc); end
      put(0, 18'h00404); put(5, 18'h01408);
      tick();
      vin = '0;
      for (int i = 0; i < 4; i++) begin
         get_word(got, ok);
         checks++; if (!ok || got !== exp2[i]) begin failures++; $display("FAIL rr_wrap%0d got=%h ok=%b exp=%h", i, got, ok, exp2[i]); end
      end
   endtask

   task automatic test_overrun();
      logic [WE-1:0] exp [4] = '{16'hA000, 16'h0300, 16'hA101, 16'h0002};
      logic [WE-1:0] got;
      bit            ok;
      rdy = 1'b0;
      put(0, 18'h00C00);
      tick();
      vin = '0;
      tick();
      put(1, 18'h00004);
      tick();
      checks++; if (drops !== 8'h00) begin failures++; $display("FAIL ovr_first_nodrop got=%h exp=00", drops); end
      put(1, 18'h00008);
      tick();
      vin = '0;
      checks++; if (drops !== 8'h02) begin failures++; $display("FAIL ovr_flag got=%h exp=02", drops); end
      rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         get_word(got, ok);
         checks++; if (!ok || got !== exp[i]) begin failures++; $display("FAIL ovr_frame%0d got=%h ok=%b exp=%h", i, got, ok, exp[i]); end
      end
      checks++; if (drops !== 8'h02) begin failures++; $display("FAIL ovr_sticky got=%h exp=02", drops); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (drops !== 8'h00) begin failures++; $display("FAIL ovr_clear got=%h exp=00", drops); end
   endtask

   task automatic test_same_cycle();
      logic [WE-1:0] exp [4] = '{16'hA400, 16'h1000, 16'hA400, 16'h2000};
      logic [WE-1:0] got;
      bit            ok;
      rdy = 1'b1;
      put(4, 18'h04000);
      tick();
      put(4, 18'h08000);
      tick();
      vin = '0;
      for (int i = 0; i < 4; i++) begin
         get_word(got, ok);
         checks++; if (!ok || got !== exp[i]) begin failures++; $display("FAIL same_frame%0d got=%h ok=%b exp=%h", i, got, ok, exp[i]); end
      end
      checks++; if (drops !== 8'h00) begin failures++; $display("FAIL same_nodrop got=%h exp=00", drops); end
   endtask

   task automatic test_reset_mid_frame();
      int nv;
      rdy = 1'b0;
      put(6, 18'h3FFFF);
      tick();
      vin = '0;
      tick();
      put(7, 18'h11111);
      rdy = 1'b1;
      tick();
      vin = '0;
      rdy = 1'b0;
      checks++; if (wv !== 1'b1 || w !== 16'hFFFF) begin failures++; $display("FAIL mid_data valid=%b word=%h exp=1,FFFF", wv, w); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (wv !== 1'b0 || w !== 16'h0 || fc !== 16'h0 || busy !== 1'b0 || drops !== 8'h0) begin
         failures++; $display("FAIL mid_reset valid=%b word=%h count=%0d busy=%b drops=%h exp=0,0000,0,0,00", wv, w, fc, busy, drops);
      end
      rdy = 1'b1;
      nv = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (wv) nv++;
      end
      checks++; if (nv !== 0) begin failures++; $display("FAIL mid_no_emit valid_cycles=%0d exp=0", nv); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_round_robin();
      test_overrun();
      test_same_cycle();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/osf_pipe_arbiter.md
# osf_pipe_arbiter

Round-robin scheduler that shares the single oversample-filter bulk-transfer pipe FIFO among all N_ADC filter channels. Each enabled channel's newest sample is held and arbitrated fairly. The granted sample is emitted as a two-word frame on a valid/ready port, so the host receives every active channel over one pipe endpoint. The block sits between the oversample filters and the pipe TX FIFO on the 50 MHz system clock. It also reports per-channel overrun.

## Interface
- N_ADC, 8, number of filter channels (max 16)
- W_ADC_DATA, 18, filter sample width
- W_EP, 16, pipe word width; data word = top W_EP bits of sample
- W_CNT, 16, frame counter width

Ports:
- clk50_in  in  1  system clock
- reset_in  in  1  reset; synchronous, active-high
- chan_en_in  in  N_ADC  channel participates in arbitration
- osf_data_valid_in  in  N_ADC  one-cycle strobe per new sample
- osf_data_packed_in  in  N_ADC*W_ADC_DATA  channel a at [a*W_ADC_DATA +: W_ADC_DATA]
- fifo_ready_in  in  1  downstream FIFO accepts word this cycle
- word_valid_out  out  1  word_out valid
- word_out  out  W_EP  header or data word
- drop_flags_out  out  N_ADC  sticky per-channel overrun
- clear_drops_in  in  1  clears drop_flags_out
- frame_count_out  out  W_CNT  completed frames, wraps
- busy_out  out  1  state != IDLE

## Operation
- Per channel: hold register, pending bit, drop_since_grant bit.
- Capture: valid[i] & chan_en_in[i] loads hold[i] and sets pending[i].
  - If pending[i] was already set and not granted this cycle, the new sample overwrites the held one and sets drop_since_grant[i] and drop_flags_out[i].
- Disabled channel: chan_en_in[i]=0 clears pending[i] and drop_since_grant[i] next cycle. A frame already in flight for that channel completes.
- Arbitration: round-robin over pending & chan_en_in.
  - Search starts at last_grant+1, mod N_ADC.
  - last_grant resets to N_ADC-1, so channel 0 wins first.
- On grant g:
  - latch chan=g, data=hold[g][W_ADC_DATA-1 -: W_EP], drop=drop_since_grant[g] into frame regs;
  - clear pending[g] and drop_since_grant[g];
  - last_grant <= g.
- Simultaneous capture and grant on the same channel: the frame takes the old held value; the new sample becomes pending. No drop is recorded.
- FSM states and transitions:
  - IDLE: any eligible pending → grant → HDR; else stay.
  - HDR: word_out = {4'hA, chan[3:0], 7'b0, drop}; accept (valid & ready) → DATA.
  - DATA: word_out = data; accept → IDLE and frame_count_out += 1 (wraps).
- Handshake: word_out and word_valid_out are registered and held stable while valid & !ready. word_valid_out=1 exactly in HDR/DATA.
- clear_drops_in clears all sticky flags. A same-cycle new overrun on a channel wins, and that flag stays set.

## Timing
- Reset values: word_valid_out=0, word_out=0, drop_flags_out=0, frame_count_out=0, busy_out=0, state IDLE, all pending/hold=0.
- Reset mid-frame aborts the frame; word_valid_out=0 the cycle after reset is sampled.
- Latency, idle and uncontended: valid at cycle t → pending at t+1 → header valid at t+2 → data at t+3 with ready held high.
- Peak throughput: one frame per 3 cycles (IDLE grant cycle + 2 words).
- Fairness: with all N channels continuously pending, each channel is granted once per N frames.

## Structure
- Shared header pipe_frame.vh holds:
  - HDR_SYNC=4'hA;
  - header field positions (sync [15:12], chan [11:8], drop [0]);
  - FSM state encodings (IDLE, HDR, DATA).
  - The host software decoder uses the same header.
- One sub-module, rr_arbiter #(N): combinational one-hot grant from request vector and last-grant pointer, plus encoded index and any_req output. The pointer register stays in the parent.
- Instantiated ahead of pipe_tx_fifo, replacing the focused-channel mux.

## Test plan
- Single sample: ch3 valid, data 18'h2ABCD, ready=1 → header 16'hA300 at t+2, data 16'hAAF3 at t+3, frame_count_out=1.
- Backpressure: ready=0 for 5 cycles in HDR → word_out stays 16'hA300, valid stays 1; state advances only on the first ready cycle.
- Round-robin: ch0, ch2, ch5 valid in the same cycle → frames ordered ch0, ch2, ch5. Then ch0 and ch5 again → ch0 is served before ch5 (pointer at 5, search from 6 wraps to 0).
- Overrun: ch1 valid twice (18'h00004, then 18'h00008) while ch0's frame is stalled → ch1 frame carries 16'h0002, header 16'hA101, drop_flags_out[1]=1. clear_drops_in with no new overrun → flag 0.
- Same-cycle capture and grant on ch4 → the frame carries the old value, the new sample is sent in the next ch4 frame, drop=0.
- Reset asserted in DATA with ready=0 → next cycle: valid=0, all outputs at reset values. A pending sample entered before reset is never emitted.
